arc4_encrypt: RTL and testbench
===============================

// Module: arc4_encrypt
// PURPOSE
//  ARC4 encryptor: writer side of the ciphertext memory the cracker reads. Takes a 24-bit key,
//  reads a length-prefixed plaintext from PT memory, runs KSA+PRGA on an internal 256x8 S-box,
//  and writes the length-prefixed ciphertext to CT memory. Uses the same rdy/en handshake as the
//  other ARC4 blocks; sits beside the cracker in the top level to produce test ciphertext on-chip.
// PARAMETERS
//  KEY_W    24   key width in bits (3 key bytes; fixed by the cracker's key space)
//  ADDR_W   8    PT/CT address width; message length <= 2**ADDR_W - 1
// PORTS
//  clk         in   1       system clock
//  rst_n       in   1       async active-low reset
//  en          in   1       start request; sampled only while rdy=1
//  rdy         out  1       1 = idle, able to accept en
//  key         in   KEY_W   key; key[23:16] = key byte 0; latched on accepted en
//  pt_addr     out  ADDR_W  PT memory read address (sync RAM, 1-cycle read latency)
//  pt_rddata   in   8       PT read data
//  ct_addr     out  ADDR_W  CT memory write address
//  ct_wrdata   out  8       CT write data
//  ct_wren     out  1       CT write strobe, one cycle per byte
//  pt_ok       out  1       plaintext printable flag (see CONFIGURATION)
// BEHAVIOUR
//  Reset: rdy=1, ct_wren=0, pt_addr=0, ct_addr=0, ct_wrdata=0, pt_ok=1, FSM=IDLE. Reset at any
//   point aborts the operation; CT contents partially written are left as is.
//  Handshake: en && rdy in cycle N -> key latched, rdy=0 from N+1. en while rdy=0 ignored.
//   rdy returns to 1 the cycle after the last CT write; en may be accepted that same cycle.
//  Memory format: byte 0 = length L (0..255), bytes 1..L = message. ct[0]=L,
//   ct[k] = pt[k] ^ pad[k-1], k=1..L.
//  FSM: IDLE -> INIT (s[i]=i, i=0..255, one write/cycle, 256 cycles) -> KSA (i=0..255:
//   read s[i]; j=(j+s[i]+key_byte[i%3]) mod 256; read s[j]; swap) -> RDLEN (read pt[0], write
//   ct[0]) -> PRGA per k=1..L (i=i+1; read s[i]; j=j+s[i]; read s[j]; swap;
//   read s[(s[i]+s[j]) mod 256]; read pt[k]; write ct[k]) -> IDLE.
//  Arithmetic: all i/j/index sums are 8-bit, wrap mod 256 by truncation; i,j cleared to 0 at
//   KSA start and again at PRGA start.
//  L=0: only ct[0]=0 written, no PRGA step; rdy returns after RDLEN.
//  L=255: ct_addr reaches 255 without wrap; no write to address 0 after ct[0].
//  i==j in a swap: S unchanged (write order must not corrupt the entry).
//  Latency bound: accepted en to rdy=1 <= 256 + 6*256 + 8*L + 8 cycles.
//  ct_wren strictly single-cycle pulses; ct_addr/ct_wrdata valid in the same cycle.
// CONFIGURATION
//  ARC4_PRINTABLE_CHECK_EN defined: pt_ok cleared at start, then latched 0 if any pt[k]
//   (k=1..L) lies outside 0x20..0x7E; held until next accepted en.
//  Not defined: pt_ok tied 1; no comparator logic synthesised. Encryption identical both ways.
// STRUCTURE
//  Package arc4_pkg: state enum (IDLE, INIT, KSA_*, RDLEN, PRGA_*), KEY_BYTES=3, S_DEPTH=256,
//   PRINT_LO=8'h20, PRINT_HI=8'h7E.
//  Sub-module arc4_s_mem: 256x8 single-port sync RAM (addr, wrdata, wren, rddata; 1-cycle read).
//  FSM, i/j/k registers and PT/CT address generation live in arc4_encrypt.
// TESTING
//  key=24'h4B6579 ("Key"), pt="Plaintext" (L=9) -> ct[0]=09, ct[1..9]=BB F3 16 E8 D9 40 AF 0A D3.
//  L=0, any key -> exactly one ct_wren, ct[0]=00; rdy back within 256+1536+8 cycles.
//  L=255, key=24'h000018 -> 256 writes, addresses 0..255 in order; bytes match bench ARC4 model.
//  en held high through a run -> second encryption starts only the cycle rdy=1; results identical.
//  rst_n pulsed low mid-KSA -> rdy=1, ct_wren=0 immediately; fresh run gives correct ct.
//  With ARC4_PRINTABLE_CHECK_EN: pt containing 8'h0A -> pt_ok=0; all-printable -> pt_ok=1.

Source files
------------

// File: rtl/arc4_pkg.sv
// ============================================================================
// Module      : arc4_pkg
// Description : Shared types and constants for the ARC4 encryptor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package arc4_pkg;

   localparam int KEY_BYTES = 3;
   localparam int S_DEPTH   = 256;
   localparam logic [7:0] PRINT_LO = 8'h20;
   localparam logic [7:0] PRINT_HI = 8'h7E;

   typedef enum logic [3:0] {
      IDLE      = 4'd0,
      INIT      = 4'd1,
      KSA_RDI   = 4'd2,
      KSA_RDJ   = 4'd3,
      KSA_WRI   = 4'd4,
      KSA_WRJ   = 4'd5,
      RDLEN     = 4'd6,
      PRGA_RDI  = 4'd7,
      PRGA_RDJ  = 4'd8,
      PRGA_WRI  = 4'd9,
      PRGA_WRJ  = 4'd10,
      PRGA_RDK  = 4'd11,
      PRGA_OUT  = 4'd12,
      DONE      = 4'd13
   } arc4_state_t;

   // Key byte 0 is the most significant byte of the key word.
   function automatic logic [7:0] key_byte(input logic [KEY_BYTES*8-1:0] k,
                                           input logic [1:0] idx);
      logic [7:0] b;
      case (idx)
         2'd0:    b = k[23:16];
         2'd1:    b = k[15:8];
         default: b = k[7:0];
      endcase
      return b;
   endfunction

endpackage

`default_nettype wire

// File: rtl/arc4_s_mem.sv
// ============================================================================
// Module      : arc4_s_mem
// Description : 256x8 single-port synchronous RAM holding the ARC4 S-box.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module arc4_s_mem
   import arc4_pkg::*;
(
   input  logic       clk,
   input  logic [7:0] addr,
   input  logic [7:0] wrdata,
   input  logic       wren,
   output logic [7:0] rddata
);

   logic [7:0] r_mem [S_DEPTH];

   always_ff @(posedge clk) begin
      if (wren) begin
         r_mem[addr] <= wrdata;
      end
      rddata <= r_mem[addr];
   end

endmodule

`default_nettype wire

// File: rtl/arc4_encrypt.sv
// ============================================================================
// Module      : arc4_encrypt
// Description : ARC4 encryptor, length-prefixed PT memory in, CT memory out.
//               Define ARC4_PRINTABLE_CHECK_EN to enable the pt_ok checker.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module arc4_encrypt
   import arc4_pkg::*;
#(
   parameter int KEY_W  = 24,
   parameter int ADDR_W = 8
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   output logic              rdy,
   input  logic [KEY_W-1:0]  key,
   output logic [ADDR_W-1:0] pt_addr,
   input  logic [7:0]        pt_rddata,
   output logic [ADDR_W-1:0] ct_addr,
   output logic [7:0]        ct_wrdata,
   output logic              ct_wren,
   output logic              pt_ok
);

   arc4_state_t r_state, w_next;

   logic [KEY_W-1:0]  r_key;
   logic [7:0]        r_i, r_j, r_si, r_sj, r_k, r_len;
   logic [1:0]        r_kidx;
   logic [ADDR_W-1:0] r_pt_addr, r_ct_addr;
   logic [7:0]        r_ct_wrdata;
   logic              r_ct_wren;

   logic [7:0] w_s_addr, w_s_wrdata, w_s_rddata;
   logic       w_s_wren, w_accept;
   logic [7:0] w_ksa_j, w_prga_j, w_i_inc;

   assign w_accept = en && (r_state == IDLE);
   assign w_ksa_j  = r_j + w_s_rddata + key_byte(r_key, r_kidx);
   assign w_prga_j = r_j + w_s_rddata;
   assign w_i_inc  = r_i + 8'd1;

   arc4_s_mem u_s_mem (
      .clk    (clk),
      .addr   (w_s_addr),
      .wrdata (w_s_wrdata),
      .wren   (w_s_wren),
      .rddata (w_s_rddata)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:     if (en) w_next = INIT;
         INIT:     if (r_i == 8'd255) w_next = KSA_RDI;
         KSA_RDI:  w_next = KSA_RDJ;
         KSA_RDJ:  w_next = KSA_WRI;
         KSA_WRI:  w_next = KSA_WRJ;
         KSA_WRJ:  w_next = (r_i == 8'd255) ? RDLEN : KSA_RDI;
         RDLEN:    w_next = (pt_rddata == 8'd0) ? DONE : PRGA_RDI;
         PRGA_RDI: w_next = PRGA_RDJ;
         PRGA_RDJ: w_next = PRGA_WRI;
         PRGA_WRI: w_next = PRGA_WRJ;
         PRGA_WRJ: w_next = PRGA_RDK;
         PRGA_RDK: w_next = PRGA_OUT;
         PRGA_OUT: w_next = (r_k == r_len) ? DONE : PRGA_RDI;
         DONE:     w_next = IDLE;
         default:  w_next = IDLE;
      endcase
   end

   // S-box port: reads present the address one cycle ahead of the data use.
   always_comb begin
      rdy        = (r_state == IDLE);
      w_s_addr   = r_i;
      w_s_wrdata = r_i;
      w_s_wren   = 1'b0;
      case (r_state)
         INIT:     w_s_wren = 1'b1;
         KSA_RDJ:  w_s_addr = w_ksa_j;
         KSA_WRI,
         PRGA_WRI: begin
            w_s_wrdata = w_s_rddata;
            w_s_wren   = 1'b1;
         end
         KSA_WRJ,
         PRGA_WRJ: begin
            w_s_addr   = r_j;
            w_s_wrdata = r_si;
            w_s_wren   = 1'b1;
         end
         PRGA_RDI: w_s_addr = w_i_inc;
         PRGA_RDJ: w_s_addr = w_prga_j;
         PRGA_RDK: w_s_addr = r_si + r_sj;
         default:  ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_key       <= '0;
         r_i         <= '0;
         r_j         <= '0;
         r_si        <= '0;
         r_sj        <= '0;
         r_k         <= '0;
         r_len       <= '0;
         r_kidx      <= '0;
         r_pt_addr   <= '0;
         r_ct_addr   <= '0;
         r_ct_wrdata <= '0;
         r_ct_wren   <= 1'b0;
      end else begin
         r_ct_wren <= 1'b0;
         case (r_state)
            IDLE: if (w_accept) begin
               r_key     <= key;
               r_i       <= '0;
               r_pt_addr <= '0;
            end
            INIT: begin
               r_i    <= w_i_inc;
               r_j    <= '0;
               r_kidx <= '0;
            end
            KSA_RDJ: begin
               r_si <= w_s_rddata;
               r_j  <= w_ksa_j;
            end
            KSA_WRJ: begin
               r_i    <= w_i_inc;
               r_kidx <= (r_kidx == 2'd2) ? 2'd0 : r_kidx + 2'd1;
            end
            RDLEN: begin
               r_i         <= '0;
               r_j         <= '0;
               r_k         <= 8'd1;
               r_len       <= pt_rddata;
               r_ct_addr   <= '0;
               r_ct_wrdata <= pt_rddata;
               r_ct_wren   <= 1'b1;
            end
            PRGA_RDI: begin
               r_i       <= w_i_inc;
               r_pt_addr <= ADDR_W'(r_k);
            end
            PRGA_RDJ: begin
               r_si <= w_s_rddata;
               r_j  <= w_prga_j;
            end
            PRGA_WRI: r_sj <= w_s_rddata;
            PRGA_OUT: begin
               r_ct_addr   <= ADDR_W'(r_k);
               r_ct_wrdata <= pt_rddata ^ w_s_rddata;
               r_ct_wren   <= 1'b1;
               r_k         <= r_k + 8'd1;
            end
            default: ;
         endcase
      end
   end

   assign pt_addr   = r_pt_addr;
   assign ct_addr   = r_ct_addr;
   assign ct_wrdata = r_ct_wrdata;
   assign ct_wren   = r_ct_wren;

`ifdef ARC4_PRINTABLE_CHECK_EN
   logic r_pt_ok;

   // Flag starts good on each accepted run and falls on the first bad byte.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pt_ok <= 1'b1;
      end else if (w_accept) begin
         r_pt_ok <= 1'b1;
      end else if ((r_state == PRGA_OUT) &&
                   ((pt_rddata < PRINT_LO) || (pt_rddata > PRINT_HI))) begin
         r_pt_ok <= 1'b0;
      end
   end

   assign pt_ok = r_pt_ok;
`else
   assign pt_ok = 1'b1;
`endif

endmodule

`default_nettype wire

// File: tb/tb_arc4_encrypt.sv
// ============================================================================
// Module      : tb_arc4_encrypt
// Description : Scoreboard bench for arc4_encrypt against a behavioural ARC4.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_arc4_encrypt;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en = 1'b0;
   logic        rdy;
   logic [23:0] key = '0;
   logic [7:0]  pt_addr, ct_addr, ct_wrdata;
   logic [7:0]  pt_rddata = '0;
   logic        ct_wren, pt_ok;

   logic [7:0]  pt_mem [256];
   logic [7:0]  ct_mem [256];
   logic [15:0] exp_q [$];
   int          n_assert = 0;
   int          n_fail = 0;
   int          n_wr = 0;
   logic        r_prev_wren = 1'b0;

   arc4_encrypt dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .rdy       (rdy),
      .key       (key),
      .pt_addr   (pt_addr),
      .pt_rddata (pt_rddata),
      .ct_addr   (ct_addr),
      .ct_wrdata (ct_wrdata),
      .ct_wren   (ct_wren),
      .pt_ok     (pt_ok)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      pt_rddata <= pt_mem[pt_addr];
      if (ct_wren) ct_mem[ct_addr] <= ct_wrdata;
   end

   task automatic check_eq(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
      n_assert++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Scoreboard consumer: every CT write must match the next expected entry.
   always @(negedge clk) begin
      if (rst_n && ct_wren) begin
         n_wr++;
         check_eq("wren_pulse", {31'd0, r_prev_wren}, 32'd0);
         if (exp_q.size() == 0) begin
            check_eq("ct_extra_write", {24'd0, ct_addr}, 32'hFFFF);
         end else begin
            logic [15:0] e;
            e = exp_q.pop_front();
            check_eq("ct_addr", {24'd0, ct_addr}, {24'd0, e[15:8]});
            check_eq("ct_data", {24'd0, ct_wrdata}, {24'd0, e[7:0]});
         end
      end
      r_prev_wren = rst_n && ct_wren;
   end

   task automatic push_model(input logic [23:0] k);
      logic [7:0] s [256];
      logic [7:0] kb [3];
      logic [7:0] t;
      int         i, j, len;
      kb[0] = k[23:16]; kb[1] = k[15:8]; kb[2] = k[7:0];
      for (int n = 0; n < 256; n++) s[n] = n[7:0];
      j = 0;
      for (int n = 0; n < 256; n++) begin
         j = (j + int'(s[n]) + int'(kb[n % 3])) & 255;
         t = s[n]; s[n] = s[j]; s[j] = t;
      end
      len = int'(pt_mem[0]);
      exp_q.push_back({8'd0, pt_mem[0]});
      i = 0; j = 0;
      for (int n = 1; n <= len; n++) begin
         i = (i + 1) & 255;
         j = (j + int'(s[i])) & 255;
         t = s[i]; s[i] = s[j]; s[j] = t;
         t = s[(int'(s[i]) + int'(s[j])) & 255];
         exp_q.push_back({n[7:0], pt_mem[n] ^ t});
      end
   endtask

   task automatic load_str(input string str);
      pt_mem[0] = str.len();
      for (int n = 0; n < str.len(); n++) pt_mem[n+1] = str[n];
   endtask

   task automatic clear_ct();
      for (int n = 0; n < 256; n++) ct_mem[n] = 8'hEE;
      n_wr = 0;
   endtask

   // Waits on negedges for rdy; returns cycles elapsed, flags an expired bound.
   task automatic wait_rdy(input int budget, output int cyc);
      cyc = 0;
      while (1) begin
         @(negedge clk);
         cyc++;
         if (rdy) break;
         if (cyc > budget) begin
            check_eq("rdy_timeout", cyc, budget);
            break;
         end
      end
   endtask

   task automatic run_enc(input logic [23:0] k, output int lat);
      int bound;
      bound = 256 + 6*256 + 8*int'(pt_mem[0]) + 8;
      push_model(k);
      @(negedge clk);
      check_eq("rdy_before", {31'd0, rdy}, 1);
      en = 1'b1; key = k;
      @(posedge clk); #1;
      en = 1'b0; key = $urandom;
      check_eq("rdy_drop", {31'd0, rdy}, 0);
      wait_rdy(bound + 16, lat);
      check_eq("latency_ok", {31'd0, lat <= bound}, 1);
      check_eq("sb_empty", exp_q.size(), 0);
   endtask

   initial begin
      logic [7:0] vec [9];
      int lat;
      vec = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
      for (int n = 0; n < 256; n++) pt_mem[n] = '0;
      clear_ct();

      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_rdy", {31'd0, rdy}, 1);
      check_eq("rst_wren", {31'd0, ct_wren}, 0);
      check_eq("rst_pt_addr", {24'd0, pt_addr}, 0);
      check_eq("rst_ct_addr", {24'd0, ct_addr}, 0);
      check_eq("rst_ct_data", {24'd0, ct_wrdata}, 0);
      check_eq("rst_pt_ok", {31'd0, pt_ok}, 1);
      @(negedge clk) rst_n = 1'b1;

      // Known-answer vector
      load_str("Plaintext");
      run_enc(24'h4B6579, lat);
      check_eq("kat_len", {24'd0, ct_mem[0]}, 9);
      for (int n = 0; n < 9; n++) check_eq("kat_byte", {24'd0, ct_mem[n+1]}, {24'd0, vec[n]});
      check_eq("kat_pt_ok", {31'd0, pt_ok}, 1);

      // Empty message
      clear_ct();
      pt_mem[0] = 8'd0;
      run_enc($urandom, lat);
      check_eq("l0_writes", n_wr, 1);
      check_eq("l0_ct0", {24'd0, ct_mem[0]}, 0);
      check_eq("l0_latency", {31'd0, lat <= 256 + 1536 + 8}, 1);

      // Maximum-length message
      clear_ct();
      pt_mem[0] = 8'd255;
      for (int n = 1; n < 256; n++) pt_mem[n] = $urandom;
      run_enc(24'h000018, lat);
      check_eq("l255_writes", n_wr, 256);
      check_eq("l255_ct0", {24'd0, ct_mem[0]}, 255);

      // en held high: second run starts exactly when rdy rises
      clear_ct();
      load_str("Plaintext");
      push_model(24'h4B6579);
      push_model(24'h4B6579);
      @(negedge clk);
      en = 1'b1; key = 24'h4B6579;
      @(posedge clk); #1;
      check_eq("hold_rdy_drop", {31'd0, rdy}, 0);
      wait_rdy(256 + 1536 + 8*9 + 24, lat);
      check_eq("hold_rdy_rise", {31'd0, rdy}, 1);
      @(posedge clk); #1;
      check_eq("hold_reaccept", {31'd0, rdy}, 0);
      en = 1'b0;
      wait_rdy(256 + 1536 + 8*9 + 24, lat);
      check_eq("hold_writes", n_wr, 20);
      check_eq("hold_sb_empty", exp_q.size(), 0);
      for (int n = 0; n < 9; n++) check_eq("hold_byte", {24'd0, ct_mem[n+1]}, {24'd0, vec[n]});

      // Reset mid-KSA, then a clean run
      clear_ct();
      @(negedge clk);
      en = 1'b1; key = 24'h123456;
      @(posedge clk); #1;
      en = 1'b0;
      repeat (400) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check_eq("abort_rdy", {31'd0, rdy}, 1);
      check_eq("abort_wren", {31'd0, ct_wren}, 0);
      check_eq("abort_writes", n_wr, 0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      run_enc(24'h4B6579, lat);
      for (int n = 0; n < 9; n++) check_eq("post_rst_byte", {24'd0, ct_mem[n+1]}, {24'd0, vec[n]});

      // Non-printable content
      clear_ct();
      load_str("Hello\nWorld");
      run_enc(24'hA5C3F0, lat);
`ifdef ARC4_PRINTABLE_CHECK_EN
      check_eq("np_pt_ok", {31'd0, pt_ok}, 0);
`else
      check_eq("np_pt_ok", {31'd0, pt_ok}, 1);
`endif
      load_str("Plaintext");
      run_enc(24'h4B6579, lat);
      check_eq("pr_pt_ok", {31'd0, pt_ok}, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
